// File: rtl/motor_uart_pkg.sv
// Shared definitions for the motor-command UART link: command codes, TX states,
// default baud divisor and the priority command encoder.
package motor_uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [7:0] CMD_STOP  = 8'h53;
    localparam logic [7:0] CMD_FWD   = 8'h46;
    localparam logic [7:0] CMD_BACK  = 8'h42;
    localparam logic [7:0] CMD_LEFT  = 8'h4C;
    localparam logic [7:0] CMD_RIGHT = 8'h52;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    // Lowest set bit wins; an all-zero command is treated as stop.
    function automatic logic [7:0] encode_cmd(input logic [4:0] cmd);
        logic [7:0] code;
        if (cmd[0])      code = CMD_STOP;
        else if (cmd[1]) code = CMD_FWD;
        else if (cmd[2]) code = CMD_BACK;
        else if (cmd[3]) code = CMD_LEFT;
        else if (cmd[4]) code = CMD_RIGHT;
        else             code = CMD_STOP;
        return code;
    endfunction

endpackage

// File: rtl/motor_uart_top_level_uart_tx.sv
// LSB-first UART transmitter with valid/ready byte input and a registered line output.
// Define MOTOR_UART_PARITY_EN to insert an even-parity bit between bit 7 and stop.
module uart_tx
    import motor_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_out
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             baud_done;

    assign baud_done = (baud_q == BAUD_LAST);
    assign tx_ready  = (state_q == TX_IDLE);
    assign tx_out    = tx_q;

    // The line level for the next bit is registered on the edge that enters that bit.
    always_comb begin
        state_d = state_q;
        baud_d  = '0;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        if (state_q != TX_IDLE && !baud_done) begin
            baud_d = baud_q + 1'b1;
        end
        case (state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (tx_valid) begin
                    state_d = TX_START;
                    data_d  = tx_data;
                    tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    state_d = TX_DATA;
                    tx_d    = data_q[0];
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    bit_d = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef MOTOR_UART_PARITY_EN
                        state_d = TX_PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = TX_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        tx_d = data_q[bit_d];
                    end
                end
            end
`ifdef MOTOR_UART_PARITY_EN
            TX_PARITY: begin
                if (baud_done) begin
                    state_d = TX_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (baud_done) begin
                    state_d = TX_IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = TX_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TX_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/motor_uart_top_level.sv
// Board top: synchronizes trigger/command, encodes a command byte on each trigger rising
// edge and queues it (one deep, last wins) for the UART transmitter driving gpio.
module motor_uart_top_level
    import motor_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [4:0] motor_cmd,
    input  logic       trigger,
    output logic       gpio
);

    logic       trig_s1_q, trig_s2_q, trig_prev_q;
    logic [4:0] cmd_s1_q, cmd_s2_q;
    logic       pend_valid_q, pend_valid_d;
    logic [7:0] pend_byte_q, pend_byte_d;
    logic       trig_rise;
    logic       tx_ready;

    assign trig_rise = trig_s2_q & ~trig_prev_q;

    // A capture in the same cycle the transmitter takes the old byte leaves the new one pending.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_byte_d  = pend_byte_q;
        if (pend_valid_q && tx_ready) begin
            pend_valid_d = 1'b0;
        end
        if (trig_rise) begin
            pend_valid_d = 1'b1;
            pend_byte_d  = encode_cmd(cmd_s2_q);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            trig_s1_q    <= 1'b0;
            trig_s2_q    <= 1'b0;
            trig_prev_q  <= 1'b0;
            cmd_s1_q     <= '0;
            cmd_s2_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_byte_q  <= '0;
        end else begin
            trig_s1_q    <= trigger;
            trig_s2_q    <= trig_s1_q;
            trig_prev_q  <= trig_s2_q;
            cmd_s1_q     <= motor_cmd;
            cmd_s2_q     <= cmd_s1_q;
            pend_valid_q <= pend_valid_d;
            pend_byte_q  <= pend_byte_d;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .clk      (CLOCK_50),
        .rst_n    (reset),
        .tx_data  (pend_byte_q),
        .tx_valid (pend_valid_q),
        .tx_ready (tx_ready),
        .tx_out   (gpio)
    );

endmodule

// File: tb/tb_motor_uart_top_level.sv
// Bench for motor_uart_top_level: a timing model of the serial line checked every cycle,
// a UART receiver decoding frames, and hand-computed literal expectations.
`timescale 1ns/1ps
module tb_motor_uart_top_level;

    localparam int N = 434;
`ifdef MOTOR_UART_PARITY_EN
    localparam int FRAME_BITS   = 11;
    localparam int GAP_EXPECTED = 4775;
`else
    localparam int FRAME_BITS   = 10;
    localparam int GAP_EXPECTED = 4341;
`endif
    localparam int FRAME_CYCLES = FRAME_BITS * N;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] motor_cmd;
    logic       trigger;
    logic       gpio;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    motor_uart_top_level #(
        .CLKS_PER_BIT(N)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .motor_cmd (motor_cmd),
        .trigger   (trigger),
        .gpio      (gpio)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, want %0h (cycle %0d)", name, actual, expected, cyc);
    endtask

    function automatic logic [7:0] expect_code(input logic [4:0] cmd);
        logic [7:0] letters [5];
        letters[0] = 8'h53;
        letters[1] = 8'h46;
        letters[2] = 8'h42;
        letters[3] = 8'h4C;
        letters[4] = 8'h52;
        for (int i = 0; i < 5; i++) begin
            if (cmd[i]) return letters[i];
        end
        return 8'h53;
    endfunction

    function automatic logic frame_level(input logic [7:0] b, input int t);
        int idx;
        logic [7:0] sh;
        idx = t / N;
        if (idx == 0) return 1'b0;
        if (idx <= 8) begin
            sh = b >> (idx - 1);
            return sh[0];
        end
`ifdef MOTOR_UART_PARITY_EN
        if (idx == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Line model: edge detection from input history, one-deep last-wins queue, frame timing.
    logic       h1, h2, h3, rise, exp_gpio;
    logic [4:0] c1, c2, rise_cmd;
    logic       m_pend, m_active;
    logic [7:0] m_pb, m_fb;
    int         m_fs, m_next_free;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            h1 = 0; h2 = 0; h3 = 0; c1 = '0; c2 = '0;
            m_pend = 0; m_active = 0; m_next_free = 0; exp_gpio = 1'b1;
        end else begin
            rise     = h2 && !h3;
            rise_cmd = c2;
            h3 = h2; h2 = h1; h1 = trigger;
            c2 = c1; c1 = motor_cmd;
            if (m_pend && cyc >= m_next_free) begin
                m_active    = 1;
                m_fs        = cyc;
                m_fb        = m_pb;
                m_pend      = 0;
                m_next_free = cyc + FRAME_CYCLES + 1;
            end
            if (rise) begin
                m_pend = 1;
                m_pb   = expect_code(rise_cmd);
            end
            if (m_active && (cyc - m_fs) < FRAME_CYCLES) exp_gpio = frame_level(m_fb, cyc - m_fs);
            else exp_gpio = 1'b1;
        end
    end

    always @(negedge clk) begin
        checkOutput("gpio_vs_model", 32'(gpio), 32'(rst_n ? exp_gpio : 1'b1));
    end

    // Receiver: samples mid-bit, records decoded bytes and start cycles.
    logic [7:0] rx_bytes [$];
    int         rx_starts [$];
    logic       rx_par [$];
    logic       rx_active = 1'b0;
    logic [7:0] rx_shift;
    int         rx_t0, rx_t, rx_i;
    int         rx_count_starts = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (gpio === 1'b0) begin
                rx_active = 1'b1;
                rx_t0     = cyc;
                rx_count_starts++;
            end
        end else begin
            rx_t = cyc - rx_t0;
            if (rx_t % N == N / 2) begin
                rx_i = rx_t / N;
                if (rx_i == 0) begin
                    checkOutput("rx_start_bit", 32'(gpio), 32'(0));
                end else if (rx_i <= 8) begin
                    rx_shift = {gpio, rx_shift[7:1]};
`ifdef MOTOR_UART_PARITY_EN
                end else if (rx_i == 9) begin
                    checkOutput("rx_parity", 32'(gpio), 32'(^rx_shift));
                    rx_par.push_back(gpio);
`endif
                end else if (rx_i == FRAME_BITS - 1) begin
                    checkOutput("rx_stop_bit", 32'(gpio), 32'(1));
                    rx_bytes.push_back(rx_shift);
                    rx_starts.push_back(rx_t0);
                    rx_active = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic [4:0] cmd, input logic trig);
        @(posedge clk);
        #1;
        motor_cmd = cmd;
        trigger   = trig;
    endtask

    task automatic pulseTrigger(input logic [4:0] cmd, output int k);
        applyStimulus(cmd, 1'b1);
        k = cyc + 1;
        applyStimulus(cmd, 1'b0);
    endtask

    task automatic waitFrames(input int n);
        int budget;
        budget = 0;
        while (rx_bytes.size() < n && budget < 3 * FRAME_CYCLES) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("frame_arrived", 32'(rx_bytes.size() >= n), 32'(1));
        repeat (N) @(negedge clk);
    endtask

    initial begin
        int k, k2, base, sbase, s;
        rst_n = 1'b1; motor_cmd = '0; trigger = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("gpio_in_reset", 32'(gpio), 32'(1));
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("idle_after_reset_gpio", 32'(gpio), 32'(1));
        checkOutput("no_frame_after_reset", 32'(rx_count_starts), 32'(0));

        $display("[TB] single forward command");
        base = rx_bytes.size();
        pulseTrigger(5'b00010, k);
        while (cyc != k + 2) @(negedge clk);
        checkOutput("gpio_high_at_k2", 32'(gpio), 32'(1));
        @(negedge clk);
        checkOutput("gpio_low_at_k3", 32'(gpio), 32'(0));
        waitFrames(base + 1);
        checkOutput("byte_fwd", 32'(rx_bytes[base]), 32'h46);
        checkOutput("start_cycle", 32'(rx_starts[base]), 32'(k + 3));
`ifdef MOTOR_UART_PARITY_EN
        checkOutput("parity_bit_0x46", 32'(rx_par[0]), 32'(1));
`endif

        $display("[TB] trigger during a frame");
        base = rx_bytes.size();
        pulseTrigger(5'b00010, k);
        repeat (250) @(posedge clk);
        pulseTrigger(5'b00100, k2);
        waitFrames(base + 2);
        checkOutput("first_byte_intact", 32'(rx_bytes[base]), 32'h46);
        checkOutput("pending_byte_back", 32'(rx_bytes[base + 1]), 32'h42);
        checkOutput("frame_spacing", 32'(rx_starts[base + 1] - rx_starts[base]), 32'(GAP_EXPECTED));

        $display("[TB] pending overwrite");
        base = rx_bytes.size();
        sbase = rx_count_starts;
        pulseTrigger(5'b00010, k);
        repeat (250) @(posedge clk);
        pulseTrigger(5'b01000, k2);
        repeat (250) @(posedge clk);
        pulseTrigger(5'b10000, k2);
        waitFrames(base + 2);
        repeat (200) @(negedge clk);
        checkOutput("overwrite_first", 32'(rx_bytes[base]), 32'h46);
        checkOutput("overwrite_last_wins", 32'(rx_bytes[base + 1]), 32'h52);
        checkOutput("overwrite_frame_count", 32'(rx_count_starts - sbase), 32'(2));

        $display("[TB] priority and empty command");
        base = rx_bytes.size();
        pulseTrigger(5'b10011, k);
        waitFrames(base + 1);
        checkOutput("priority_stop", 32'(rx_bytes[base]), 32'h53);
        pulseTrigger(5'b00000, k);
        waitFrames(base + 2);
        checkOutput("empty_is_stop", 32'(rx_bytes[base + 1]), 32'h53);

        $display("[TB] trigger held high");
        base = rx_bytes.size();
        sbase = rx_count_starts;
        applyStimulus(5'b01000, 1'b1);
        repeat (FRAME_CYCLES + 600) @(posedge clk);
        applyStimulus(5'b01000, 1'b0);
        repeat (10) @(negedge clk);
        checkOutput("held_one_frame", 32'(rx_count_starts - sbase), 32'(1));
        checkOutput("held_byte_left", 32'(rx_bytes[base]), 32'h4C);

        $display("[TB] reset during data bits");
        base = rx_bytes.size();
        sbase = rx_count_starts;
        pulseTrigger(5'b01000, k);
        s = k + 3;
        repeat (100) @(posedge clk);
        pulseTrigger(5'b10000, k2);
        while (cyc != s + 2 * N + N / 2) @(negedge clk);
        checkOutput("gpio_mid_data", 32'(gpio), 32'(0));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 checkOutput("gpio_async_reset", 32'(gpio), 32'(1));
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (FRAME_CYCLES + 200) @(negedge clk);
        checkOutput("aborted_no_resume", 32'(rx_count_starts - sbase), 32'(1));
        checkOutput("aborted_no_byte", 32'(rx_bytes.size()), 32'(base));
        pulseTrigger(5'b10000, k);
        waitFrames(base + 1);
        checkOutput("recover_byte_right", 32'(rx_bytes[base]), 32'h52);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
